// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one external memory port between IF and MEM stages
//
// Ports:
//   clk, reset_n                     clock and asynchronous active-low reset
//   if_req/if_addr -> if_rdata/if_done          instruction fetch request and completion
//   dm_read/dm_write/dm_addr/dm_wdata -> dm_rdata/dm_done   data load/store and completion
//   mem_req/mem_we/mem_addr/mem_wdata, mem_rdata/mem_ready  external memory handshake
//   if_stall, pipe_stall             combinational pipeline freeze signals
//   bus_err                          sticky memory timeout flag
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_done,
  input  logic             dm_read,
  input  logic             dm_write,
  input  logic [WIDTH-1:0] dm_addr,
  input  logic [WIDTH-1:0] dm_wdata,
  output logic [WIDTH-1:0] dm_rdata,
  output logic             dm_done,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready,
  output logic             if_stall,
  output logic             pipe_stall,
  output logic             bus_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  // Counter value on the last permitted wait cycle; mem_req is high for
  // exactly TIMEOUT cycles when the memory never answers.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             mem_req_q, mem_req_d;
  logic             mem_we_q, mem_we_d;
  logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [WIDTH-1:0] dm_rdata_q, dm_rdata_d;
  logic             if_done_q, if_done_d;
  logic             dm_done_q, dm_done_d;
  logic             bus_err_q, bus_err_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
    bus_err_d   = bus_err_q;

    case (state_q)
      S_IDLE: begin
        // Data wins over fetch: it belongs to the older instruction.
        if (dm_read || dm_write) begin
          state_d     = S_DATA;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_write;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          cnt_d       = 16'd0;
        end else if (if_req) begin
          state_d    = S_FETCH;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          cnt_d      = 16'd0;
        end
      end
      S_FETCH, S_DATA: begin
        if (mem_ready || (cnt_q == CNT_LAST)) begin
          state_d   = S_RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          cnt_d     = 16'd0;
          if (!mem_ready) begin
            bus_err_d = 1'b1;
          end
          // A timed-out access still completes, returning zero data.
          if (state_q == S_FETCH) begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            dm_done_d = 1'b1;
            if (!mem_ready) begin
              dm_rdata_d = '0;
            end else if (!mem_we_q) begin
              dm_rdata_d = mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        // RESP: requests are deliberately not sampled here so a request still
        // held for the serviced access is not issued a second time.
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 16'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign bus_err   = bus_err_q;

  // Stalls release on the done cycle so the pipeline advances at that edge.
  assign pipe_stall = (dm_read | dm_write) & ~dm_done_q;
  assign if_stall   = (if_req & ~if_done_q) | pipe_stall;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares a single external memory port between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 5-stage MIPS pipeline.
- Sequences multi-cycle memory transactions through a req/ready handshake.
- Generates the stall signals that freeze the PC, IF/ID and the wider pipeline while accesses are outstanding.
- Sits beside the hazard detection logic; its stalls are ORed with the load-use stall by the top level.

Parameters:
- WIDTH, 32, data and address width in bits.
- TIMEOUT, 255, maximum cycles to wait for mem_ready before aborting the transaction; legal range 1..65535.

Ports:
- clk  input  1  single system clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- if_req  input  1  IF stage requests an instruction; held until if_done.
- if_addr  input  WIDTH  fetch address (PC).
- if_rdata  output  WIDTH  fetched instruction, valid while if_done=1.
- if_done  output  1  one-cycle fetch completion pulse.
- dm_read  input  1  MEM stage load request; held until dm_done.
- dm_write  input  1  MEM stage store request; held until dm_done.
- dm_addr  input  WIDTH  data address (ALU result).
- dm_wdata  input  WIDTH  store data.
- dm_rdata  output  WIDTH  load data, valid while dm_done=1.
- dm_done  output  1  one-cycle data completion pulse.
- mem_req  output  1  external memory request.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  WIDTH  external address.
- mem_wdata  output  WIDTH  external write data.
- mem_rdata  input  WIDTH  external read data.
- mem_ready  input  1  external completion, sampled only while mem_req=1.
- if_stall  output  1  hold PC and IF/ID.
- pipe_stall  output  1  freeze all pipeline registers.
- bus_err  output  1  sticky timeout flag.

Behaviour:

Reset (reset_n low, asynchronous, including mid-transaction):
- State goes to IDLE.
- mem_req, mem_we, if_done, dm_done and bus_err go to 0.
- mem_addr, mem_wdata, if_rdata, dm_rdata and the wait counter go to 0.
- Any in-flight transaction is abandoned. No done pulse is issued for it after reset releases.

State machine (IDLE, FETCH, DATA, RESP). All non-stall outputs are registered.

IDLE:
- If dm_read or dm_write is high, go to DATA. Data has priority because it belongs to the older instruction.
  - Capture dm_addr into mem_addr.
  - Capture dm_wdata into mem_wdata.
  - Set mem_we = dm_write. If dm_read and dm_write are both high, write wins.
- Else if if_req is high, go to FETCH, capture if_addr, set mem_we = 0.
- mem_req = 1 from the first cycle in FETCH/DATA.
- mem_ready while in IDLE is ignored.

FETCH / DATA:
- mem_req, mem_we, mem_addr and mem_wdata stay stable until mem_ready is sampled high.
- The wait counter increments every cycle.
- On mem_ready=1:
  - FETCH: latch mem_rdata into if_rdata.
  - DATA, read: latch mem_rdata into dm_rdata.
  - Deassert mem_req, clear the counter, go to RESP.
- If the counter reaches TIMEOUT before mem_ready:
  - Set bus_err = 1. It is sticky until reset.
  - Deassert mem_req, latch 0 as read data, go to RESP.
  - The requester still receives a done pulse.

RESP (exactly one cycle):
- Asserts if_done (after FETCH) or dm_done (after DATA). The pulse is exactly one cycle.
- Next state is always IDLE.
- Requests are not sampled in RESP. This prevents a still-held, already-serviced request from being reissued.

Stalls (combinational):
- pipe_stall = (dm_read | dm_write) & ~dm_done.
- if_stall = (if_req & ~if_done) | pipe_stall.
- On the done cycle the stall drops, the pipeline advances at that edge, and the requester presents its next request by the following IDLE cycle.

Timing:
- Minimum latency from request in IDLE to done is 2 + N cycles, where N is the memory wait: 1 cycle to issue, N cycles of mem_req until mem_ready, 1 RESP cycle.
- Back-to-back transactions are separated by one IDLE cycle.

Simultaneous events:
- if_req and a data request both pending in IDLE: DATA is served first, then FETCH starting from the next IDLE. The fetch is never dropped.
- A request that deasserts while its transaction is in flight (illegal) is still completed. Its done pulse is issued and ignored.

Test Plan:
- Reset, then if_req=1, if_addr=0x0000_0040, memory ready after 2 cycles with rdata=0x2008_0005 -> mem_req high for cycles 1–3 with mem_we=0 and mem_addr=0x40; if_done pulses one cycle with if_rdata=0x2008_0005; if_stall high until that cycle.
- dm_write=1, dm_addr=0x100, dm_wdata=0xCAFEF00D, ready after 1 cycle -> mem_we=1, mem_wdata=0xCAFEF00D; dm_done pulses once; pipe_stall and if_stall high until dm_done.
- if_req and dm_read asserted in the same IDLE cycle -> data transaction issued first (mem_addr=dm_addr); then an IDLE cycle; then a fetch with mem_addr=if_addr; dm_done precedes if_done.
- Request held through RESP -> exactly one mem_req transaction and one done pulse; no duplicate access.
- TIMEOUT=4, mem_ready held low -> mem_req drops after 4 wait cycles; bus_err=1 and stays 1; dm_done pulses with dm_rdata=0.
- reset_n pulled low while in DATA with mem_req=1 -> all outputs 0 immediately, asynchronous to clk; no done pulse after release; bus_err=0.
